// File: rtl/bp_retire_queue.sv
// In-order retire queue for predicted branches.
// Feeds resolved outcomes back to the predictor and flushes on a mispredict.
module bp_retire_queue #(
    parameter  int DEPTH  = 16,
    localparam int SLOT_W = $clog2(DEPTH),
    localparam int IDX_W  = SLOT_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_valid,
    input  logic              alloc_cond,
    input  logic              alloc_direct,
    input  logic              alloc_return,
    input  logic [31:0]       alloc_pc,
    input  logic              alloc_pred_taken,
    input  logic [31:0]       alloc_pred_target,
    input  logic [IDX_W-1:0]  alloc_index,
    output logic              alloc_ready,
    output logic [SLOT_W-1:0] alloc_slot,
    input  logic              res_valid,
    input  logic [SLOT_W-1:0] res_slot,
    input  logic              res_taken,
    input  logic [31:0]       res_target,
    output logic              rt_en_branch,
    output logic              rt_cond_branch,
    output logic              rt_direct_branch,
    output logic              rt_return_branch,
    output logic              rt_branch_taken,
    output logic              rt_prediction_correct,
    output logic [31:0]       rt_pc,
    output logic [31:0]       rt_calculated_pc,
    output logic [IDX_W-1:0]  rt_branch_index,
    output logic              mispredict_flush,
    output logic [SLOT_W:0]   count
);

    localparam logic [SLOT_W:0] FULL = (SLOT_W + 1)'(DEPTH);

    typedef struct packed {
        logic             cond;
        logic             direct;
        logic             ret;
        logic [31:0]      pc;
        logic             pt;
        logic [31:0]      ptgt;
        logic [IDX_W-1:0] idx;
        logic             rt;
        logic [31:0]      rtgt;
    } ent_t;

    ent_t              ent [DEPTH];
    logic [DEPTH-1:0]  vld;
    logic [DEPTH-1:0]  rsv;
    logic [SLOT_W-1:0] head;
    logic [SLOT_W-1:0] tail;

    ent_t h;
    logic ret;
    logic ok;
    logic flush;
    logic do_alloc;
    logic do_res;

    assign alloc_ready = (count < FULL);
    assign alloc_slot  = tail;

    assign h        = ent[head];
    assign ret      = vld[head] && rsv[head];
    assign ok       = (h.rt == h.pt) && (!h.rt || h.rtgt == h.ptgt);
    assign flush    = ret && !ok;
    assign do_alloc = alloc_valid && alloc_ready && !flush;
    assign do_res   = res_valid && vld[res_slot] && !rsv[res_slot] && !flush;

    // Payload carries no reset; the valid/resolved flags gate its use.
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            ent[tail].cond   <= alloc_cond;
            ent[tail].direct <= alloc_direct;
            ent[tail].ret    <= alloc_return;
            ent[tail].pc     <= alloc_pc;
            ent[tail].pt     <= alloc_pred_taken;
            ent[tail].ptgt   <= alloc_pred_target;
            ent[tail].idx    <= alloc_index;
        end
        if (do_res) begin
            ent[res_slot].rt   <= res_taken;
            ent[res_slot].rtgt <= res_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld                   <= '0;
            rsv                   <= '0;
            head                  <= '0;
            tail                  <= '0;
            count                 <= '0;
            rt_en_branch          <= 1'b0;
            rt_cond_branch        <= 1'b0;
            rt_direct_branch      <= 1'b0;
            rt_return_branch      <= 1'b0;
            rt_branch_taken       <= 1'b0;
            rt_prediction_correct <= 1'b0;
            rt_pc                 <= '0;
            rt_calculated_pc      <= '0;
            rt_branch_index       <= '0;
            mispredict_flush      <= 1'b0;
        end else begin
            rt_en_branch          <= ret;
            rt_cond_branch        <= ret && h.cond;
            rt_direct_branch      <= ret && h.direct;
            rt_return_branch      <= ret && h.ret;
            rt_branch_taken       <= ret && h.rt;
            rt_prediction_correct <= ret && ok;
            rt_pc                 <= ret ? h.pc : '0;
            rt_calculated_pc      <= !ret ? '0 :
                                     h.rt ? h.rtgt : h.pc + 32'd4;
            rt_branch_index       <= ret ? h.idx : '0;
            mispredict_flush      <= flush;
            if (flush) begin
                vld   <= '0;
                rsv   <= '0;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (ret) begin
                    vld[head] <= 1'b0;
                    rsv[head] <= 1'b0;
                    head      <= head + 1'b1;
                end
                if (do_alloc) begin
                    vld[tail] <= 1'b1;
                    rsv[tail] <= 1'b0;
                    tail      <= tail + 1'b1;
                end
                if (do_res) begin
                    rsv[res_slot] <= 1'b1;
                end
                count <= count + (SLOT_W + 1)'(do_alloc)
                               - (SLOT_W + 1)'(ret);
            end
        end
    end

endmodule

// File: tb/tb_bp_retire_queue.sv
// Directed bench for bp_retire_queue.
// Allocations are modelled per slot; retires are checked against a slot-order queue.
module tb_bp_retire_queue;

    localparam int D  = 16;
    localparam int SW = 4;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          alloc_valid = 1'b0;
    logic          alloc_cond = 1'b0;
    logic          alloc_direct = 1'b0;
    logic          alloc_return = 1'b0;
    logic [31:0]   alloc_pc = '0;
    logic          alloc_pred_taken = 1'b0;
    logic [31:0]   alloc_pred_target = '0;
    logic [IW-1:0] alloc_index = '0;
    logic          alloc_ready;
    logic [SW-1:0] alloc_slot;
    logic          res_valid = 1'b0;
    logic [SW-1:0] res_slot = '0;
    logic          res_taken = 1'b0;
    logic [31:0]   res_target = '0;
    logic          rt_en_branch;
    logic          rt_cond_branch;
    logic          rt_direct_branch;
    logic          rt_return_branch;
    logic          rt_branch_taken;
    logic          rt_prediction_correct;
    logic [31:0]   rt_pc;
    logic [31:0]   rt_calculated_pc;
    logic [IW-1:0] rt_branch_index;
    logic          mispredict_flush;
    logic [SW:0]   count;

    bp_retire_queue #(.DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_cond(alloc_cond),
        .alloc_direct(alloc_direct), .alloc_return(alloc_return),
        .alloc_pc(alloc_pc), .alloc_pred_taken(alloc_pred_taken),
        .alloc_pred_target(alloc_pred_target), .alloc_index(alloc_index),
        .alloc_ready(alloc_ready), .alloc_slot(alloc_slot),
        .res_valid(res_valid), .res_slot(res_slot),
        .res_taken(res_taken), .res_target(res_target),
        .rt_en_branch(rt_en_branch), .rt_cond_branch(rt_cond_branch),
        .rt_direct_branch(rt_direct_branch),
        .rt_return_branch(rt_return_branch),
        .rt_branch_taken(rt_branch_taken),
        .rt_prediction_correct(rt_prediction_correct),
        .rt_pc(rt_pc), .rt_calculated_pc(rt_calculated_pc),
        .rt_branch_index(rt_branch_index),
        .mispredict_flush(mispredict_flush), .count(count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [2:0]    m_cls  [D];
    logic [31:0]   m_pc   [D];
    logic          m_pt   [D];
    logic [31:0]   m_ptgt [D];
    logic [IW-1:0] m_idx  [D];
    logic          m_rt   [D];
    logic [31:0]   m_rtgt [D];
    logic [SW-1:0] m_tail = '0;
    int            m_cnt = 0;
    int            q[$];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic alloc(input logic [31:0] pc, input logic [2:0] cls,
                         input logic pt, input logic [31:0] tgt,
                         input logic [IW-1:0] idx);
        logic acc;
        chk("alloc_slot", 64'(alloc_slot), 64'(m_tail));
        acc = (m_cnt < D);
        {alloc_cond, alloc_direct, alloc_return} = cls;
        alloc_pc = pc;
        alloc_pred_taken = pt;
        alloc_pred_target = tgt;
        alloc_index = idx;
        alloc_valid = 1'b1;
        @(posedge clk);
        if (acc) begin
            m_cls[m_tail] = cls;
            m_pc[m_tail] = pc;
            m_pt[m_tail] = pt;
            m_ptgt[m_tail] = tgt;
            m_idx[m_tail] = idx;
            q.push_back(int'(m_tail));
            m_tail = m_tail + 1'b1;
            m_cnt++;
        end
        #1 alloc_valid = 1'b0;
    endtask

    task automatic resolve(input logic [SW-1:0] s, input logic tk,
                           input logic [31:0] tgt);
        res_slot = s;
        res_taken = tk;
        res_target = tgt;
        res_valid = 1'b1;
        m_rt[s] = tk;
        m_rtgt[s] = tgt;
        @(posedge clk);
        #1 res_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q.delete();
        m_tail = '0;
        m_cnt = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Every retire is matched against the oldest outstanding allocation.
    always @(negedge clk) begin
        int s;
        logic ok;
        logic [31:0] calc;
        if (rst_n && mispredict_flush && !rt_en_branch)
            chk("flush_alone", 64'(mispredict_flush), 64'd0);
        if (rst_n && rt_en_branch) begin
            if (q.size() == 0) begin
                chk("unexp_retire", 64'(rt_en_branch), 64'd0);
            end else begin
                s = q.pop_front();
                ok = (m_rt[s] == m_pt[s]) &&
                     (!m_rt[s] || m_rtgt[s] == m_ptgt[s]);
                calc = m_rt[s] ? m_rtgt[s] : m_pc[s] + 32'd4;
                chk("rt_pc", 64'(rt_pc), 64'(m_pc[s]));
                chk("rt_calc", 64'(rt_calculated_pc), 64'(calc));
                chk("rt_idx", 64'(rt_branch_index), 64'(m_idx[s]));
                chk("rt_taken", 64'(rt_branch_taken), 64'(m_rt[s]));
                chk("rt_cls",
                    64'({rt_cond_branch, rt_direct_branch, rt_return_branch}),
                    64'(m_cls[s]));
                chk("rt_ok", 64'(rt_prediction_correct), 64'(ok));
                chk("flush", 64'(mispredict_flush), 64'(!ok));
                m_cnt--;
                if (!ok) begin
                    q.delete();
                    m_tail = '0;
                    m_cnt = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SW-1:0] s0;
        logic          pt;
        logic [31:0]   tgt;

        #1 rst_n = 1'b0;
        #2;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ready", 64'(alloc_ready), 64'd1);
        chk("rst_en", 64'(rt_en_branch), 64'd0);
        chk("rst_flush", 64'(mispredict_flush), 64'd0);
        chk("rst_pc", 64'(rt_pc), 64'd0);
        chk("rst_slot", 64'(alloc_slot), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_count", 64'(count), 64'd0);
        chk("idle_en", 64'(rt_en_branch), 64'd0);
        chk("idle_calc", 64'(rt_calculated_pc), 64'd0);

        alloc(32'h100, 3'b100, 1'b1, 32'h200, 5'd5);
        chk("one_count", 64'(count), 64'd1);
        resolve(4'd0, 1'b1, 32'h200);
        @(posedge clk);
        #1;
        chk("one_en", 64'(rt_en_branch), 64'd1);
        chk("one_ok", 64'(rt_prediction_correct), 64'd1);
        chk("one_calc", 64'(rt_calculated_pc), 64'h200);
        chk("one_idx", 64'(rt_branch_index), 64'd5);
        chk("one_cnt0", 64'(count), 64'd0);
        @(posedge clk);
        #1;
        chk("one_pulse", 64'(rt_en_branch), 64'd0);

        for (int i = 0; i < D; i++)
            alloc(32'h1000 + 32'(i * 4), 3'(i % 8), 1'b1,
                  32'h3000 + 32'(i), 5'(i));
        chk("full_ready", 64'(alloc_ready), 64'd0);
        chk("full_count", 64'(count), 64'(D));
        alloc(32'hdead, 3'b111, 1'b0, 32'h0, 5'd31);
        chk("full_ignore", 64'(count), 64'(D));
        for (int i = D - 1; i >= 0; i--)
            resolve(SW'(1 + i), 1'b1, 32'h3000 + 32'(i));
        for (int i = 0; i < D; i++) begin
            @(posedge clk);
            #1;
            chk("burst_en", 64'(rt_en_branch), 64'd1);
        end
        @(posedge clk);
        #1;
        chk("burst_done", 64'(rt_en_branch), 64'd0);
        chk("burst_cnt", 64'(count), 64'd0);

        do_reset();
        alloc(32'h40, 3'b100, 1'b1, 32'h80, 5'd1);
        alloc(32'h50, 3'b010, 1'b0, 32'h0, 5'd2);
        alloc(32'h60, 3'b001, 1'b1, 32'h90, 5'd3);
        resolve(4'd1, 1'b0, 32'h0);
        resolve(4'd2, 1'b1, 32'h90);
        resolve(4'd0, 1'b0, 32'h0);
        alloc_pc = 32'h999;
        alloc_valid = 1'b1;
        @(posedge clk);
        #1 alloc_valid = 1'b0;
        chk("mp_ok", 64'(rt_prediction_correct), 64'd0);
        chk("mp_calc", 64'(rt_calculated_pc), 64'h44);
        chk("mp_flush", 64'(mispredict_flush), 64'd1);
        chk("mp_count", 64'(count), 64'd0);
        chk("mp_slot", 64'(alloc_slot), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("mp_quiet", 64'(count), 64'd0);

        for (int i = 0; i < 3 * D; i++) begin
            s0 = m_tail;
            pt = 1'($urandom);
            tgt = $urandom;
            alloc($urandom, 3'($urandom), pt, tgt, 5'($urandom));
            resolve(s0, pt, pt ? tgt : $urandom);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("wrap_cnt", 64'(count), 64'd0);

        s0 = m_tail;
        for (int i = 0; i < 4; i++)
            alloc(32'h700 + 32'(i * 4), 3'b100, 1'b0, 32'h0, 5'(i));
        resolve(s0 + 4'd1, 1'b0, 32'h0);
        resolve(s0 + 4'd2, 1'b0, 32'h0);
        chk("pre_rst_cnt", 64'(count), 64'd4);
        rst_n = 1'b0;
        q.delete();
        m_tail = '0;
        m_cnt = 0;
        #2;
        chk("mid_rst_cnt", 64'(count), 64'd0);
        chk("mid_rst_rdy", 64'(alloc_ready), 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        resolve(s0, 1'b0, 32'h0);
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_cnt", 64'(count), 64'd0);
        chk("post_rst_en", 64'(rt_en_branch), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
